// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory port signals seen by the arbiter.
// Valid/ready semantics on both CPU ports: a requester raises READ (or WRITE) with
// ADDRESS/WRITEDATA/FUNC3 stable and holds them while its BUSYWAIT is 1; the single
// cycle in which BUSYWAIT is 0 with the request still up is the acceptance cycle, and
// READDATA is valid in that cycle. Toward memory the arbiter holds M_READ/M_WRITE with
// stable address/data until it samples M_BUSYWAIT=0 after the first strobe cycle.
interface mem_port_arbiter_if;
    logic        I_READ;
    logic [31:0] I_ADDRESS;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ;
    logic        D_WRITE;
    logic [2:0]  D_FUNC3;
    logic [31:0] D_ADDRESS;
    logic [31:0] D_WRITEDATA;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        M_READ;
    logic        M_WRITE;
    logic [2:0]  M_FUNC3;
    logic [31:0] M_ADDRESS;
    logic [31:0] M_WRITEDATA;
    logic [31:0] M_READDATA;
    logic        M_BUSYWAIT;

    // Arbiter side.
    modport slave (
        input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_FUNC3, D_ADDRESS, D_WRITEDATA,
               M_READDATA, M_BUSYWAIT,
        output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
               M_READ, M_WRITE, M_FUNC3, M_ADDRESS, M_WRITEDATA
    );

    // CPU plus memory side.
    modport master (
        output I_READ, I_ADDRESS, D_READ, D_WRITE, D_FUNC3, D_ADDRESS, D_WRITEDATA,
               M_READDATA, M_BUSYWAIT,
        input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
               M_READ, M_WRITE, M_FUNC3, M_ADDRESS, M_WRITEDATA
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction-fetch
// port (I) and the data port (D). D has priority; a saturating counter of D grants
// taken while I waits forces an I grant once it reaches MAX_IWAIT.
module mem_port_arbiter #(
    parameter int MAX_IWAIT = 4,
    parameter int CW        = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        dbg_state_o,
    output logic [CW-1:0]     dbg_cnt_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_IWAIT);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;     // 0 = I, 1 = D
    logic          first_q, first_d;     // first GRANT cycle: memory busy not yet visible
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_read_q, m_read_d;
    logic          m_write_q, m_write_d;
    logic [2:0]    m_func3_q, m_func3_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic i_req;
    logic d_req;
    logic i_forced;

    assign i_req    = bus.I_READ;
    assign d_req    = bus.D_READ | bus.D_WRITE;
    assign i_forced = i_req && (cnt_q == MAX_CNT);

    // Next-state: arbitration in IDLE, completion tracking in GRANT, one-cycle DONE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        first_d   = first_q;
        cnt_d     = cnt_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_func3_d = m_func3_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    state_d   = GRANT;
                    owner_d   = 1'b1;
                    first_d   = 1'b1;
                    m_addr_d  = bus.D_ADDRESS;
                    m_wdata_d = bus.D_WRITEDATA;
                    m_func3_d = bus.D_FUNC3;
                    // A combined read+write request is served as a store.
                    m_write_d = bus.D_WRITE;
                    m_read_d  = !bus.D_WRITE;
                    if (i_req && (cnt_q < MAX_CNT)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (i_req) begin
                    state_d   = GRANT;
                    owner_d   = 1'b0;
                    first_d   = 1'b1;
                    m_addr_d  = bus.I_ADDRESS;
                    m_wdata_d = 32'h0;
                    m_func3_d = 3'b010;
                    m_write_d = 1'b0;
                    m_read_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            GRANT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!bus.M_BUSYWAIT) begin
                    state_d   = DONE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (m_read_q) begin
                        if (owner_q) begin
                            d_rdata_d = bus.M_READDATA;
                        end else begin
                            i_rdata_d = bus.M_READDATA;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered memory-side/read-data outputs; async reset drops strobes at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            first_q   <= 1'b0;
            cnt_q     <= '0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_func3_q <= 3'b000;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            first_q   <= first_d;
            cnt_q     <= cnt_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_func3_q <= m_func3_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Stall each requester unless it is the owner in the DONE cycle.
    always_comb begin
        bus.I_BUSYWAIT = i_req & !((state_q == DONE) & !owner_q);
        bus.D_BUSYWAIT = d_req & !((state_q == DONE) & owner_q);
    end

    assign bus.I_READDATA  = i_rdata_q;
    assign bus.D_READDATA  = d_rdata_q;
    assign bus.M_READ      = m_read_q;
    assign bus.M_WRITE     = m_write_q;
    assign bus.M_FUNC3     = m_func3_q;
    assign bus.M_ADDRESS   = m_addr_q;
    assign bus.M_WRITEDATA = m_wdata_q;
    assign dbg_state_o     = state_q;
    assign dbg_cnt_o       = cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory with variable busy time, per-port
// request drivers, and a negedge monitor popping expected-response queues.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MAX_IWAIT = 4;
  localparam int CW = 3;
  localparam int TMO = 300;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic rd;
    logic wr;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic CLK;
  logic RESET;
  logic [1:0] dbg_state;
  logic [CW-1:0] dbg_cnt;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_IWAIT(MAX_IWAIT), .CW(CW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus),
    .dbg_state_o(dbg_state),
    .dbg_cnt_o(dbg_cnt)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  txn_t i_mem_q[$];
  txn_t d_mem_q[$];
  logic [31:0] ref_mem [0:127];
  logic [31:0] d_last;
  int d_done_cnt = 0;
  int fixed_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[8:2]);
  endfunction

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 4) return 32'h00A00093;
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic txn_t mk_txn(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.rd = rd; t.wr = wr; t.f3 = f3; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // ---------------- behavioural memory ----------------
  logic [31:0] phys_mem [0:127];
  logic [127:0] wvalid = '0;
  int mstate;
  int lat;

  function automatic logic [31:0] phys_read(input logic [31:0] a);
    return wvalid[widx(a)] ? phys_mem[widx(a)] : init_word(widx(a));
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bus.M_BUSYWAIT <= 1'b0;
      bus.M_READDATA <= 32'h0;
      mstate <= 0;
      lat <= 0;
    end else begin
      case (mstate)
        0: if (bus.M_READ || bus.M_WRITE) begin
             bus.M_BUSYWAIT <= 1'b1;
             lat <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
             mstate <= 1;
           end
        1: if (lat <= 1) begin
             bus.M_BUSYWAIT <= 1'b0;
             mstate <= 2;
             if (bus.M_WRITE) begin
               phys_mem[widx(bus.M_ADDRESS)] <= bus.M_WRITEDATA;
               wvalid[widx(bus.M_ADDRESS)] <= 1'b1;
             end else begin
               bus.M_READDATA <= phys_read(bus.M_ADDRESS);
             end
           end else begin
             lat <= lat - 1;
           end
        default: if (!(bus.M_READ || bus.M_WRITE)) mstate <= 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic mem_seen;
    logic i_read_prev;
    int starve;
    txn_t e;
    logic [31:0] x;
    mem_seen = 1'b0;
    i_read_prev = 1'b0;
    starve = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        mem_seen = 1'b0;
        starve = 0;
      end else begin
        if ((bus.M_READ || bus.M_WRITE) && !mem_seen) begin
          mem_seen = 1'b1;
          if (bus.M_ADDRESS < 32'h100) begin
            starve = 0;
            if (i_mem_q.size() == 0) chk("i_mem_unexpected", 32'(bus.M_ADDRESS), 32'hFFFFFFFF);
            else begin
              e = i_mem_q.pop_front();
              chk("i_mem_addr", bus.M_ADDRESS, e.addr);
              chk("i_mem_ctl", 32'({bus.M_READ, bus.M_WRITE, bus.M_FUNC3}), 32'({e.rd, e.wr, e.f3}));
            end
          end else begin
            if (i_read_prev) begin
              starve++;
              chk("starve_bound", 32'(starve <= MAX_IWAIT), 32'd1);
            end
            if (d_mem_q.size() == 0) chk("d_mem_unexpected", 32'(bus.M_ADDRESS), 32'hFFFFFFFF);
            else begin
              e = d_mem_q.pop_front();
              chk("d_mem_addr", bus.M_ADDRESS, e.addr);
              chk("d_mem_ctl", 32'({bus.M_READ, bus.M_WRITE, bus.M_FUNC3}), 32'({e.rd, e.wr, e.f3}));
              if (e.wr) chk("d_mem_wdata", bus.M_WRITEDATA, e.wdata);
            end
          end
        end
        if (!(bus.M_READ || bus.M_WRITE)) mem_seen = 1'b0;
        if (bus.I_READ && !bus.I_BUSYWAIT) begin
          if (i_exp_q.size() == 0) chk("i_unexpected_done", bus.I_READDATA, 32'hFFFFFFFF);
          else begin
            x = i_exp_q.pop_front();
            chk("i_readdata", bus.I_READDATA, x);
          end
        end
        if ((bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT) begin
          d_done_cnt++;
          if (d_exp_q.size() == 0) chk("d_unexpected_done", bus.D_READDATA, 32'hFFFFFFFF);
          else begin
            x = d_exp_q.pop_front();
            chk("d_readdata", bus.D_READDATA, x);
          end
        end
      end
      i_read_prev = bus.I_READ;
    end
  end

  // ---------------- drivers ----------------
  task automatic i_issue(input logic [31:0] addr);
    bus.I_READ = 1'b1;
    bus.I_ADDRESS = addr;
    i_exp_q.push_back(ref_mem[widx(addr)]);
    i_mem_q.push_back(mk_txn(1'b1, 1'b0, 3'b010, addr, 32'h0));
  endtask

  task automatic i_wait(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.I_BUSYWAIT && n < TMO);
    chk("i_timeout", 32'(bus.I_BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    bus.I_READ = 1'b0;
  endtask

  task automatic d_issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.D_READ = rd;
    bus.D_WRITE = wr;
    bus.D_FUNC3 = f3;
    bus.D_ADDRESS = addr;
    bus.D_WRITEDATA = wdata;
    if (wr) begin
      ref_mem[widx(addr)] = wdata;
      d_exp_q.push_back(d_last);
      d_mem_q.push_back(mk_txn(1'b0, 1'b1, f3, addr, wdata));
    end else begin
      d_last = ref_mem[widx(addr)];
      d_exp_q.push_back(d_last);
      d_mem_q.push_back(mk_txn(1'b1, 1'b0, f3, addr, 32'h0));
    end
  endtask

  task automatic d_wait(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.D_BUSYWAIT && n < TMO);
    chk("d_timeout", 32'(bus.D_BUSYWAIT), 32'd0);
    @(posedge CLK);
    #1;
    bus.D_READ = 1'b0;
    bus.D_WRITE = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n, ni, nd, base, d_at_i, dones;
    for (int k = 0; k < 128; k++) ref_mem[k] = init_word(k);
    d_last = 32'h0;
    bus.I_READ = 1'b0; bus.I_ADDRESS = 32'h0;
    bus.D_READ = 1'b0; bus.D_WRITE = 1'b0; bus.D_FUNC3 = 3'b000;
    bus.D_ADDRESS = 32'h0; bus.D_WRITEDATA = 32'h0;
    RESET = 1'b1;
    #1 RESET = 1'b0;

    // Reset with a fetch pending: memory side quiet, fetch stalled, grant right after release.
    i_issue(32'h80);
    repeat (2) @(negedge CLK);
    chk("rst_m_ctl", 32'({bus.M_READ, bus.M_WRITE, bus.M_FUNC3}), 32'd0);
    chk("rst_m_addr", bus.M_ADDRESS, 32'h0);
    chk("rst_m_wdata", bus.M_WRITEDATA, 32'h0);
    chk("rst_i_busy", 32'(bus.I_BUSYWAIT), 32'd1);
    chk("rst_rdata", bus.I_READDATA | bus.D_READDATA, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("rst_release_grant", 32'({dbg_state, bus.M_READ}), 32'({ST_GRANT, 1'b1}));
    i_wait(n);

    // Fetch only, memory busy for 3 cycles.
    fixed_lat = 3;
    i_issue(32'h10);
    fork
      i_wait(n);
      begin
        @(posedge CLK); #1;
        chk("fetch_m_read", 32'(bus.M_READ), 32'd1);
        chk("fetch_m_func3", 32'(bus.M_FUNC3), 32'(3'b010));
        chk("fetch_m_addr", bus.M_ADDRESS, 32'h10);
      end
    join
    chk("fetch_latency", 32'(n), 32'd7);
    chk("fetch_rdata", bus.I_READDATA, 32'h00A00093);

    // Collision: store wins first, fetch completes afterwards.
    fixed_lat = 1;
    i_issue(32'h20);
    d_issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    fork
      i_wait(ni);
      d_wait(nd);
      begin
        @(posedge CLK); #1;
        chk("coll_m_ctl", 32'({bus.M_READ, bus.M_WRITE}), 32'({1'b0, 1'b1}));
        chk("coll_m_wdata", bus.M_WRITEDATA, 32'hDEADBEEF);
        chk("coll_m_addr", bus.M_ADDRESS, 32'h100);
      end
    join
    chk("coll_order", 32'(ni > nd), 32'd1);

    // Starvation: fetch held, loads back to back; fetch must be the 5th grant.
    fixed_lat = 2;
    base = d_done_cnt;
    d_at_i = -1;
    fork
      begin
        i_issue(32'h40);
        i_wait(n);
        d_at_i = d_done_cnt - base;
        chk("starve_cnt_reset", 32'(dbg_cnt), 32'd0);
      end
      begin
        for (int k = 0; k < 6; k++) begin
          d_issue(1'b1, 1'b0, 3'b010, 32'h180 + 32'(k * 4), 32'h0);
          d_wait(nd);
        end
      end
    join
    chk("starve_d_before_i", 32'(d_at_i), 32'(MAX_IWAIT));

    // Load and store together: served as a store, load data unchanged.
    d_issue(1'b1, 1'b1, 3'b000, 32'h120, 32'h13572468);
    fork
      d_wait(nd);
      begin
        @(posedge CLK); #1;
        chk("ldst_m_ctl", 32'({bus.M_READ, bus.M_WRITE}), 32'({1'b0, 1'b1}));
      end
    join
    chk("ldst_rdata_hold", bus.D_READDATA, d_last);

    // Reset in the middle of a busy data read: abandoned, no DONE.
    fixed_lat = 3;
    bus.D_READ = 1'b1; bus.D_WRITE = 1'b0; bus.D_FUNC3 = 3'b010; bus.D_ADDRESS = 32'h140;
    d_mem_q.push_back(mk_txn(1'b1, 1'b0, 3'b010, 32'h140, 32'h0));
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_pre", 32'({dbg_state, bus.M_BUSYWAIT, bus.M_READ}), 32'({ST_GRANT, 1'b1, 1'b1}));
    #2 RESET = 1'b0;
    #1;
    chk("mid_m_read", 32'(bus.M_READ), 32'd0);
    chk("mid_d_rdata", bus.D_READDATA, 32'h0);
    chk("mid_state", 32'(dbg_state), 32'(ST_IDLE));
    bus.D_READ = 1'b0;
    d_last = 32'h0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (dbg_state == ST_DONE) dones++;
    end
    chk("mid_no_done", 32'(dones), 32'd0);

    // Randomized traffic on both ports.
    fixed_lat = 0;
    @(posedge CLK); #1;
    fork
      begin
        int g, w;
        for (int k = 0; k < 30; k++) begin
          g = int'($urandom_range(0, 3));
          if (g > 0) begin repeat (g) @(posedge CLK); #1; end
          i_issue({24'h0, 6'($urandom_range(0, 63)), 2'b00});
          i_wait(w);
        end
      end
      begin
        int g, w, op;
        for (int k = 0; k < 30; k++) begin
          g = int'($urandom_range(0, 3));
          if (g > 0) begin repeat (g) @(posedge CLK); #1; end
          op = int'($urandom_range(0, 3));
          d_issue(op != 2, op >= 2, 3'($urandom_range(0, 7)),
                  32'h100 + {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
          d_wait(w);
        end
      end
    join
    repeat (5) @(negedge CLK);
    chk("drain_i_exp", 32'(i_exp_q.size()), 32'd0);
    chk("drain_d_exp", 32'(d_exp_q.size()), 32'd0);
    chk("drain_i_mem", 32'(i_mem_q.size()), 32'd0);
    chk("drain_d_mem", 32'(d_mem_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
